// File: rtl/mod_exp_ctrl_pkg.sv
// Shared definitions for the modular-exponentiation sequencer.
//   SIZE_DEF : default operand width (base, exponent, modulus, result)
//   state_t  : sequencer states
//   op_t     : tag of the reduction currently in flight
package mod_exp_ctrl_pkg;

  localparam int SIZE_DEF = 64;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WB,
    DONE
  } state_t;

  // RED reduces the raw base, MUL folds the square into the result,
  // SQR advances the running square.
  typedef enum logic [1:0] {
    RED,
    MUL,
    SQR
  } op_t;

endpackage

// File: rtl/mod_exp_ctrl_if.sv
// Bus bundle of the modular-exponentiation sequencer.
//   cmd_* : command channel from the cipher top level (base, exponent, modulus)
//   res_* : result channel back to the cipher top level, plus busy
//   mod_* : the three AXI-stream channels to the external modulo unit
// Modport master is the sequencer; slave is its environment.
interface mod_exp_ctrl_if
  import mod_exp_ctrl_pkg::*;
#(
  parameter int SIZE = SIZE_DEF
);
  logic [SIZE-1:0]   cmd_base_tdata;
  logic [SIZE-1:0]   cmd_exp_tdata;
  logic [SIZE-1:0]   cmd_mod_tdata;
  logic              cmd_tvalid;
  logic              cmd_tready;

  logic [SIZE-1:0]   res_tdata;
  logic              res_err;
  logic              res_tvalid;
  logic              res_tready;
  logic              busy;

  logic [2*SIZE-1:0] mod_dividend_tdata;
  logic              mod_dividend_tvalid;
  logic              mod_dividend_tready;
  logic [SIZE-1:0]   mod_divisor_tdata;
  logic              mod_divisor_tvalid;
  logic              mod_divisor_tready;
  logic [SIZE-1:0]   mod_rem_tdata;
  logic              mod_rem_tvalid;
  logic              mod_rem_tready;

  modport master (
    input  cmd_base_tdata, cmd_exp_tdata, cmd_mod_tdata, cmd_tvalid,
    output cmd_tready,
    output res_tdata, res_err, res_tvalid, busy,
    input  res_tready,
    output mod_dividend_tdata, mod_dividend_tvalid,
    input  mod_dividend_tready,
    output mod_divisor_tdata, mod_divisor_tvalid,
    input  mod_divisor_tready,
    input  mod_rem_tdata, mod_rem_tvalid,
    output mod_rem_tready
  );

  modport slave (
    output cmd_base_tdata, cmd_exp_tdata, cmd_mod_tdata, cmd_tvalid,
    input  cmd_tready,
    input  res_tdata, res_err, res_tvalid, busy,
    output res_tready,
    input  mod_dividend_tdata, mod_dividend_tvalid,
    output mod_dividend_tready,
    input  mod_divisor_tdata, mod_divisor_tvalid,
    output mod_divisor_tready,
    output mod_rem_tdata, mod_rem_tvalid,
    input  mod_rem_tready
  );

endinterface

// File: rtl/mod_req_port.sv
// Request port towards the modulo unit. Holds the dividend and divisor
// registers, runs the two input channels independently and captures the
// remainder once both inputs have been taken.
//   start       : load operand/modulus and raise both tvalids
//   in_wait     : sequencer is waiting for the remainder
//   operand     : 2*SIZE dividend to send; modulus : divisor to send
//   dvd_* / dvs_* / rem_* : modulo unit channels
//   rem_done    : remainder handshake this cycle; rem : captured remainder
module mod_req_port
  import mod_exp_ctrl_pkg::*;
#(
  parameter int SIZE = SIZE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_wait,
  input  logic [2*SIZE-1:0] operand,
  input  logic [SIZE-1:0]   modulus,
  output logic [2*SIZE-1:0] dvd_tdata,
  output logic              dvd_tvalid,
  input  logic              dvd_tready,
  output logic [SIZE-1:0]   dvs_tdata,
  output logic              dvs_tvalid,
  input  logic              dvs_tready,
  input  logic [SIZE-1:0]   rem_tdata,
  input  logic              rem_tvalid,
  output logic              rem_tready,
  output logic              rem_done,
  output logic [SIZE-1:0]   rem
);

  logic dvd_sent;
  logic dvs_sent;

  // Sent flags are registers, so rem_tready never follows an input
  // combinationally.
  assign rem_tready = in_wait && dvd_sent && dvs_sent;
  assign rem_done   = rem_tready && rem_tvalid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvd_tdata  <= '0;
      dvs_tdata  <= '0;
      dvd_tvalid <= 1'b0;
      dvs_tvalid <= 1'b0;
      dvd_sent   <= 1'b0;
      dvs_sent   <= 1'b0;
      rem        <= '0;
    end else begin
      if (start) begin
        dvd_tdata  <= operand;
        dvs_tdata  <= modulus;
        dvd_tvalid <= 1'b1;
        dvs_tvalid <= 1'b1;
        dvd_sent   <= 1'b0;
        dvs_sent   <= 1'b0;
      end else begin
        if (dvd_tvalid && dvd_tready) begin
          dvd_tvalid <= 1'b0;
          dvd_sent   <= 1'b1;
        end
        if (dvs_tvalid && dvs_tready) begin
          dvs_tvalid <= 1'b0;
          dvs_sent   <= 1'b1;
        end
      end
      if (rem_done) rem <= rem_tdata;
    end
  end

endmodule

// File: rtl/mod_exp_ctrl.sv
// ElGamal modular exponentiation sequencer (base^exp mod m), right-to-left
// square-and-multiply. Each full-width product is reduced by one
// transaction on the external modulo unit.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : command, result and modulo-unit channels (master side)
module mod_exp_ctrl
  import mod_exp_ctrl_pkg::*;
#(
  parameter int SIZE = SIZE_DEF
) (
  input logic           clk,
  input logic           rst,
  mod_exp_ctrl_if.master bus
);

  state_t            state, state_d;
  op_t               op, op_d;
  logic [SIZE-1:0]   acc, sq, e, m, e_chk, mul_a, rem_q;
  logic [2*SIZE-1:0] prod, operand;
  logic              err, res_vld, busy_r, run_en;
  logic              cmd_rdy, special, start, in_wait, rem_done;

  assign cmd_rdy = run_en && (state == IDLE);
  assign start   = (state == ISSUE);
  assign in_wait = (state == WAIT);
  assign special = (bus.cmd_mod_tdata <= SIZE'(1)) || (bus.cmd_exp_tdata == '0);

  // Product stage: unsigned full-width product, registered as the dividend
  assign mul_a   = (op == MUL) ? acc : sq;
  assign prod    = {{SIZE{1'b0}}, mul_a} * {{SIZE{1'b0}}, sq};
  assign operand = (op == RED) ? {{SIZE{1'b0}}, sq} : prod;

  assign bus.cmd_tready = cmd_rdy;
  assign bus.res_tdata  = acc;
  assign bus.res_err    = err;
  assign bus.res_tvalid = res_vld;
  assign bus.busy       = busy_r;

  mod_req_port #(.SIZE(SIZE)) u_req (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_wait    (in_wait),
    .operand    (operand),
    .modulus    (m),
    .dvd_tdata  (bus.mod_dividend_tdata),
    .dvd_tvalid (bus.mod_dividend_tvalid),
    .dvd_tready (bus.mod_dividend_tready),
    .dvs_tdata  (bus.mod_divisor_tdata),
    .dvs_tvalid (bus.mod_divisor_tvalid),
    .dvs_tready (bus.mod_divisor_tready),
    .rem_tdata  (bus.mod_rem_tdata),
    .rem_tvalid (bus.mod_rem_tvalid),
    .rem_tready (bus.mod_rem_tready),
    .rem_done   (rem_done),
    .rem        (rem_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      op    <= RED;
    end else begin
      state <= state_d;
      op    <= op_d;
    end
  end

  // The bit test after a square looks at the exponent as it will be once
  // that square's shift lands, so the decision is taken in WB itself.
  always_comb begin
    state_d = state;
    op_d    = op;
    e_chk   = (op == SQR) ? (e >> 1) : e;
    case (state)
      IDLE: begin
        if (cmd_rdy && bus.cmd_tvalid) begin
          if (special) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            op_d    = RED;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT:  if (rem_done) state_d = WB;
      WB: begin
        if (op == MUL) begin
          if (e > SIZE'(1)) begin
            state_d = ISSUE;
            op_d    = SQR;
          end else begin
            state_d = DONE;
          end
        end else if (e_chk[0]) begin
          state_d = ISSUE;
          op_d    = MUL;
        end else if (e_chk > SIZE'(1)) begin
          state_d = ISSUE;
          op_d    = SQR;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    if (bus.res_tready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Writeback stage: operand latch, remainder writeback, registered status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      sq      <= '0;
      e       <= '0;
      m       <= '0;
      err     <= 1'b0;
      res_vld <= 1'b0;
      busy_r  <= 1'b0;
      run_en  <= 1'b0;
    end else begin
      run_en  <= 1'b1;
      res_vld <= (state_d == DONE);
      busy_r  <= (state_d != IDLE);
      case (state)
        IDLE: begin
          if (cmd_rdy && bus.cmd_tvalid) begin
            m   <= bus.cmd_mod_tdata;
            e   <= bus.cmd_exp_tdata;
            sq  <= bus.cmd_base_tdata;
            acc <= (bus.cmd_mod_tdata <= SIZE'(1)) ? '0 : SIZE'(1);
            err <= (bus.cmd_mod_tdata == '0);
          end
        end
        WB: begin
          case (op)
            RED: sq <= rem_q;
            MUL: acc <= rem_q;
            SQR: begin
              sq <= rem_q;
              e  <= e >> 1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl: a modulo-unit responder with configurable channel
// delays checks every transaction against a plain square-and-multiply model;
// directed commands check results, special cases, back-pressure and reset.
module tb_mod_exp_ctrl;
  import mod_exp_ctrl_pkg::*;

  localparam int SIZE = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mod_exp_ctrl_if #(.SIZE(SIZE)) bus ();

  mod_exp_ctrl #(.SIZE(SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int           n_vec = 0;
  int           n_err = 0;
  logic [127:0] exp_dd[$];
  logic [63:0]  exp_m = '0;
  int           tx_count = 0;
  int           traffic = 0;
  bit           rnd_mode = 1'b0;
  int           dd_fix = 0;
  int           dv_fix = 0;
  int           rem_fix = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  function automatic int pick(input int fix);
    if (rnd_mode) return int'($urandom_range(0, 20));
    return fix;
  endfunction

  // Right-to-left square-and-multiply; records every dividend the modulo
  // unit must see, in order.
  task automatic ref_model(input logic [63:0] b, input logic [63:0] ee, input logic [63:0] mm,
                           output logic [63:0] r, output int ntx);
    logic [127:0] acc, sq, p, m128;
    logic [63:0]  ev;
    ntx  = 0;
    m128 = {64'd0, mm};
    if (mm <= 64'd1) begin
      r = '0;
    end else if (ee == 64'd0) begin
      r = 64'd1;
    end else begin
      ev  = ee;
      acc = 128'd1;
      exp_dd.push_back({64'd0, b});
      ntx = 1;
      sq  = {64'd0, b} % m128;
      while (1) begin
        if (ev[0]) begin
          p = acc * sq;
          exp_dd.push_back(p);
          acc = p % m128;
          ntx++;
        end
        if (ev > 64'd1) begin
          p = sq * sq;
          exp_dd.push_back(p);
          sq = p % m128;
          ev = ev >> 1;
          ntx++;
        end else begin
          break;
        end
      end
      r = acc[63:0];
    end
  endtask

  // Modulo-unit responder and per-cycle protocol checker.
  initial begin : modulo_model
    bit           dd_got, dv_got, dd_arm, dv_arm, rem_arm, rem_pend, dd_hs, dv_hs;
    bit           pdd_v, pdd_hs, pdv_v, pdv_hs;
    int           dd_w, dv_w, rem_w;
    logic [127:0] dd_cap, pdd;
    logic [63:0]  dv_cap, pdv;
    dd_got = 0; dv_got = 0; dd_arm = 0; dv_arm = 0; rem_arm = 0; rem_pend = 0;
    pdd_v = 0; pdd_hs = 0; pdv_v = 0; pdv_hs = 0;
    dd_w = 0; dv_w = 0; rem_w = 0; dd_cap = '0; dv_cap = '0; pdd = '0; pdv = '0;
    bus.mod_dividend_tready = 1'b0;
    bus.mod_divisor_tready  = 1'b0;
    bus.mod_rem_tvalid      = 1'b0;
    bus.mod_rem_tdata       = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        dd_got = 0; dv_got = 0; dd_arm = 0; dv_arm = 0; rem_arm = 0; rem_pend = 0;
        pdd_v = 0; pdd_hs = 0; pdv_v = 0; pdv_hs = 0;
        bus.mod_dividend_tready = 1'b0;
        bus.mod_divisor_tready  = 1'b0;
        bus.mod_rem_tvalid      = 1'b0;
        bus.mod_rem_tdata       = '0;
      end else begin
        if (rem_pend) begin
          rem_pend = 0; dd_got = 0; dv_got = 0; dd_arm = 0; dv_arm = 0; rem_arm = 0;
          bus.mod_rem_tvalid = 1'b0;
          tx_count++;
        end
        if (bus.mod_rem_tready) chk("rem_tready_early", dd_got && dv_got, 1'b1);
        if (bus.mod_dividend_tvalid || bus.mod_divisor_tvalid) traffic++;
        if (pdd_v && !pdd_hs) begin
          chk("dd_valid_hold", bus.mod_dividend_tvalid, 1'b1);
          chk("dd_data_hold", bus.mod_dividend_tdata, pdd);
        end
        if (pdv_v && !pdv_hs) begin
          chk("dv_valid_hold", bus.mod_divisor_tvalid, 1'b1);
          chk("dv_data_hold", bus.mod_divisor_tdata, pdv);
        end
        // dividend channel
        dd_hs = 0;
        bus.mod_dividend_tready = 1'b0;
        if (!dd_got && bus.mod_dividend_tvalid) begin
          if (!dd_arm) begin dd_arm = 1; dd_w = pick(dd_fix); end
          if (dd_w > 0) begin
            dd_w--;
          end else begin
            bus.mod_dividend_tready = 1'b1;
            dd_hs = 1; dd_got = 1;
            dd_cap = bus.mod_dividend_tdata;
            if (exp_dd.size() == 0) begin
              n_vec++; n_err++;
              $display("FAIL dd_unexpected: got %0h, required no transaction", dd_cap);
            end else begin
              chk("dd_value", dd_cap, exp_dd.pop_front());
            end
          end
        end
        pdd_v = bus.mod_dividend_tvalid; pdd = bus.mod_dividend_tdata; pdd_hs = dd_hs;
        // divisor channel
        dv_hs = 0;
        bus.mod_divisor_tready = 1'b0;
        if (!dv_got && bus.mod_divisor_tvalid) begin
          if (!dv_arm) begin dv_arm = 1; dv_w = pick(dv_fix); end
          if (dv_w > 0) begin
            dv_w--;
          end else begin
            bus.mod_divisor_tready = 1'b1;
            dv_hs = 1; dv_got = 1;
            dv_cap = bus.mod_divisor_tdata;
            chk("dv_value", dv_cap, exp_m);
          end
        end
        pdv_v = bus.mod_divisor_tvalid; pdv = bus.mod_divisor_tdata; pdv_hs = dv_hs;
        // remainder channel; may be offered before the DUT is ready for it
        if (dd_got && dv_got && !rem_pend) begin
          if (!rem_arm) begin rem_arm = 1; rem_w = pick(rem_fix); end
          if (rem_w > 0) begin
            rem_w--;
          end else begin
            bus.mod_rem_tvalid = 1'b1;
            bus.mod_rem_tdata  = (dv_cap == 0) ? 64'd0 : 64'(dd_cap % {64'd0, dv_cap});
            if (bus.mod_rem_tready) rem_pend = 1;
          end
        end
      end
    end
  end

  task automatic run(input logic [63:0] b, input logic [63:0] ee, input logic [63:0] mm,
                     input bit has_lit, input logic [63:0] lit, input logic lit_err,
                     input int hold, input string nm);
    logic [63:0] r;
    int          ntx, waited;
    bit          special;
    special = (mm <= 64'd1) || (ee == 64'd0);
    exp_dd.delete();
    exp_m = mm;
    ref_model(b, ee, mm, r, ntx);
    if (has_lit) chk({nm, "_model"}, r, lit);
    tx_count = 0;
    traffic  = 0;
    waited   = 0;
    while (!bus.cmd_tready && waited < 100) begin @(negedge clk); waited++; end
    chk({nm, "_cmd_ready"}, bus.cmd_tready, 1'b1);
    bus.cmd_base_tdata = b;
    bus.cmd_exp_tdata  = ee;
    bus.cmd_mod_tdata  = mm;
    bus.cmd_tvalid     = 1'b1;
    @(negedge clk);
    bus.cmd_tvalid = 1'b0;
    chk({nm, "_busy"}, bus.busy, 1'b1);
    chk({nm, "_cmd_ready_low"}, bus.cmd_tready, 1'b0);
    waited = 0;
    while (!bus.res_tvalid && waited < 5000) begin @(negedge clk); waited++; end
    if (special) chk({nm, "_latency"}, waited, 0);
    chk({nm, "_res_valid"}, bus.res_tvalid, 1'b1);
    chk({nm, "_res"}, bus.res_tdata, r);
    chk({nm, "_err"}, bus.res_err, lit_err);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, "_hold_res"}, bus.res_tdata, r);
      chk({nm, "_hold_valid"}, bus.res_tvalid, 1'b1);
      chk({nm, "_hold_cmd_ready"}, bus.cmd_tready, 1'b0);
    end
    bus.res_tready = 1'b1;
    @(negedge clk);
    bus.res_tready = 1'b0;
    chk({nm, "_res_valid_drop"}, bus.res_tvalid, 1'b0);
    chk({nm, "_cmd_ready_back"}, bus.cmd_tready, 1'b1);
    chk({nm, "_busy_drop"}, bus.busy, 1'b0);
    chk({nm, "_ntx"}, tx_count, ntx);
    chk({nm, "_queue_empty"}, exp_dd.size(), 0);
    if (special) chk({nm, "_no_traffic"}, traffic, 0);
  endtask

  initial begin : main
    logic [63:0] r;
    int          ntx, waited;
    bus.cmd_base_tdata = '0;
    bus.cmd_exp_tdata  = '0;
    bus.cmd_mod_tdata  = '0;
    bus.cmd_tvalid     = 1'b0;
    bus.res_tready     = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_tready", bus.cmd_tready, 1'b0);
    chk("rst_res_tvalid", bus.res_tvalid, 1'b0);
    chk("rst_res_tdata", bus.res_tdata, 64'd0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_dd_tvalid", bus.mod_dividend_tvalid, 1'b0);
    chk("rst_rem_tready", bus.mod_rem_tready, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    // 3^5 mod 7 = 243 mod 7 = 5; 1 RED + 2 MUL + 2 SQR
    run(64'd3, 64'd5, 64'd7, 1'b1, 64'd5, 1'b0, 0, "basic");
    chk("basic_ntx_literal", tx_count, 5);

    // 10^3 mod 7 = 1000 mod 7 = 6, random channel delays
    rnd_mode = 1'b1;
    run(64'd10, 64'd3, 64'd7, 1'b1, 64'd6, 1'b0, 0, "rnd");
    rnd_mode = 1'b0;

    run(64'd4, 64'd0, 64'd13, 1'b1, 64'd1, 1'b0, 0, "e0");
    run(64'd5, 64'd9, 64'd1, 1'b1, 64'd0, 1'b0, 0, "m1");
    run(64'd5, 64'd9, 64'd0, 1'b1, 64'd0, 1'b1, 0, "m0");

    // 2^10 mod 1000 = 1024 mod 1000 = 24, result held back 10 cycles
    run(64'd2, 64'd10, 64'd1000, 1'b1, 64'd24, 1'b0, 10, "bp");

    run(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFC5,
        1'b0, 64'd0, 1'b0, 0, "full");
    chk("full_ntx_literal", tx_count, 128);

    // reset while the second reduction is outstanding
    exp_dd.delete();
    exp_m = 64'd7;
    ref_model(64'd3, 64'd5, 64'd7, r, ntx);
    dd_fix = 2; rem_fix = 3; tx_count = 0;
    waited = 0;
    while (!bus.cmd_tready && waited < 100) begin @(negedge clk); waited++; end
    bus.cmd_base_tdata = 64'd3;
    bus.cmd_exp_tdata  = 64'd5;
    bus.cmd_mod_tdata  = 64'd7;
    bus.cmd_tvalid     = 1'b1;
    @(negedge clk);
    bus.cmd_tvalid = 1'b0;
    waited = 0;
    while (!(tx_count >= 1 && bus.mod_dividend_tvalid) && waited < 500) begin
      @(negedge clk); waited++;
    end
    chk("rstop_reached_second_op", (tx_count >= 1) && bus.mod_dividend_tvalid, 1'b1);
    rst = 1'b0;
    #1;
    chk("rstop_cmd_tready", bus.cmd_tready, 1'b0);
    chk("rstop_res_tvalid", bus.res_tvalid, 1'b0);
    chk("rstop_res_tdata", bus.res_tdata, 64'd0);
    chk("rstop_res_err", bus.res_err, 1'b0);
    chk("rstop_busy", bus.busy, 1'b0);
    chk("rstop_dd_tvalid", bus.mod_dividend_tvalid, 1'b0);
    chk("rstop_dv_tvalid", bus.mod_divisor_tvalid, 1'b0);
    chk("rstop_rem_tready", bus.mod_rem_tready, 1'b0);
    chk("rstop_dd_tdata", bus.mod_dividend_tdata, 128'd0);
    chk("rstop_dv_tdata", bus.mod_divisor_tdata, 64'd0);
    repeat (2) @(negedge clk);
    dd_fix = 0; rem_fix = 0;
    rst = 1'b1;
    @(negedge clk);
    run(64'd3, 64'd5, 64'd7, 1'b1, 64'd5, 1'b0, 0, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
